// File: rtl/mux_arbiter2.sv
// Two-requester round-robin arbiter that owns a shared WIDTH-bit 2:1 mux.
// It issues registered grants, supports bounded bursts and registers the selected beat with a valid flag.
module mux_arbiter2 #(
    parameter int WIDTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             last0,
    input  logic             last1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    localparam int          CNT_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [31:0] MAX_BURST_U = 32'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;

    logic               own_idx_s;
    logic               own_req_s;
    logic               own_last_s;
    logic               other_req_s;
    logic               at_max_s;
    logic               release_s;

    // Next-state, burst counting, round-robin priority and beat capture.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        count_d     = count_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        own_idx_s   = (state_q == OWN1);
        own_req_s   = own_idx_s ? req1 : req0;
        own_last_s  = own_idx_s ? last1 : last0;
        other_req_s = own_idx_s ? req0 : req1;
        at_max_s    = ((32'(count_q) + 32'd1) == MAX_BURST_U);
        release_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = prio_q ? OWN1 : OWN0;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (own_req_s) begin
                    // A beat always uses the currently selected mux leg.
                    out_d     = sel_q ? data1 : data0;
                    valid_d   = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                    release_s = own_last_s || at_max_s;
                end else begin
                    release_s = 1'b1;
                end

                if (release_s) begin
                    count_d = '0;
                    prio_d  = ~own_idx_s;
                    if (other_req_s) begin
                        state_d = own_idx_s ? OWN0 : OWN1;
                    end else if (own_req_s) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Grants and select follow the next owner; select holds while idle.
    always_comb begin
        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
        if (state_d == OWN0) begin
            sel_d = 1'b0;
        end else if (state_d == OWN1) begin
            sel_d = 1'b1;
        end else begin
            sel_d = sel_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            count_q <= '0;
            sel_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign sel   = sel_q;
    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter2.sv
// Bench for mux_arbiter2: vector table, directed corner sequences and random traffic
// checked against an owner/priority/burst-count reference model.
module tb_mux_arbiter2;

    localparam int WIDTH     = 64;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1, last0, last1;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, sel, valid;
    logic [WIDTH-1:0] out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner -1 means nobody holds the path.
    int               m_owner;
    int               m_prio;
    int               m_cnt;
    logic             m_sel;
    logic             m_valid;
    logic [WIDTH-1:0] m_out;

    typedef struct {
        logic             r0, r1, l0, l1;
        logic [WIDTH-1:0] d0, d1;
        logic             g0, g1, s, v;
        logic [WIDTH-1:0] o;
    } vec_t;

    vec_t tbl[$];

    mux_arbiter2 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .last0(last0), .last1(last1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out(out), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_prio = 0; m_cnt = 0;
        m_sel = 1'b0; m_valid = 1'b0; m_out = '0;
    endtask

    task automatic model_step();
        logic             rq[2];
        logic             lt[2];
        logic [WIDTH-1:0] dt[2];
        bit               done;
        int               x;
        rq[0] = req0; rq[1] = req1; lt[0] = last0; lt[1] = last1;
        dt[0] = data0; dt[1] = data1;
        m_valid = 1'b0;
        if (m_owner < 0) begin
            if (rq[0] && rq[1]) m_owner = m_prio;
            else if (rq[0])     m_owner = 0;
            else if (rq[1])     m_owner = 1;
        end else begin
            x = m_owner;
            done = 1'b0;
            if (rq[x]) begin
                m_out   = dt[x];
                m_valid = 1'b1;
                m_cnt++;
                done = lt[x] || (m_cnt == MAX_BURST);
            end else begin
                done = 1'b1;
            end
            if (done) begin
                m_cnt  = 0;
                m_prio = 1 - x;
                if (rq[1-x])  m_owner = 1 - x;
                else if (rq[x]) m_owner = x;
                else          m_owner = -1;
            end
        end
        if (m_owner >= 0) m_sel = (m_owner == 1);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_gnt0"},  64'(gnt0),  64'(m_owner == 0));
        chk({tag, "_gnt1"},  64'(gnt1),  64'(m_owner == 1));
        chk({tag, "_sel"},   64'(sel),   64'(m_sel));
        chk({tag, "_valid"}, 64'(valid), 64'(m_valid));
        chk({tag, "_out"},   out,        m_out);
    endtask

    task automatic drive(input logic r0, input logic r1, input logic l0, input logic l1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        req0 = r0; req1 = r1; last0 = l0; last1 = l1; data0 = d0; data1 = d1;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_model(tag);
    endtask

    task automatic add(input logic r0, input logic r1, input logic l0, input logic l1,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                       input logic g0, input logic g1, input logic s, input logic v,
                       input logic [WIDTH-1:0] o);
        vec_t e;
        e.r0 = r0; e.r1 = r1; e.l0 = l0; e.l1 = l1; e.d0 = d0; e.d1 = d1;
        e.g0 = g0; e.g1 = g1; e.s = s; e.v = v; e.o = o;
        tbl.push_back(e);
    endtask

    initial begin
        //   r0    r1    l0    l1    data0   data1   g0    g1    sel   valid out
        add(1'b1, 1'b0, 1'b0, 1'b0, 64'hA,  64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 64'hA,  64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 64'hA);
        add(1'b1, 1'b0, 1'b0, 1'b0, 64'hB,  64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 64'hB);
        add(1'b1, 1'b0, 1'b1, 1'b0, 64'hC,  64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 64'hC);
        add(1'b0, 1'b0, 1'b0, 1'b0, 64'hD,  64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 64'hC);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'hE,  64'h10, 1'b0, 1'b1, 1'b1, 1'b0, 64'hC);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'hE,  64'h11, 1'b0, 1'b1, 1'b1, 1'b1, 64'h11);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'hE,  64'h12, 1'b0, 1'b1, 1'b1, 1'b1, 64'h12);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'hE,  64'h13, 1'b0, 1'b1, 1'b1, 1'b1, 64'h13);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'hE,  64'h14, 1'b1, 1'b0, 1'b0, 1'b1, 64'h14);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'h21, 64'h15, 1'b1, 1'b0, 1'b0, 1'b1, 64'h21);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'h22, 64'h15, 1'b1, 1'b0, 1'b0, 1'b1, 64'h22);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'h23, 64'h15, 1'b1, 1'b0, 1'b0, 1'b1, 64'h23);
        add(1'b1, 1'b1, 1'b0, 1'b0, 64'h24, 64'h15, 1'b0, 1'b1, 1'b1, 1'b1, 64'h24);
        add(1'b1, 1'b1, 1'b0, 1'b1, 64'h24, 64'h55, 1'b1, 1'b0, 1'b0, 1'b1, 64'h55);
        add(1'b1, 1'b1, 1'b1, 1'b0, 64'h66, 64'h55, 1'b0, 1'b1, 1'b1, 1'b1, 64'h66);
        add(1'b0, 1'b1, 1'b0, 1'b0, 64'h66, 64'h55, 1'b0, 1'b1, 1'b1, 1'b1, 64'h55);
        add(1'b0, 1'b0, 1'b0, 1'b1, 64'h66, 64'h55, 1'b0, 1'b0, 1'b1, 1'b0, 64'h55);

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", 64'(gnt0), 64'h0);
        chk("rst_gnt1", 64'(gnt1), 64'h0);
        chk("rst_sel", 64'(sel), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_out", out, 64'h0);
        #3 reset = 1'b0;
        #1;

        // Table: single burst, tie with round-robin, forced release and handovers.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].d0, tbl[i].d1);
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_gnt0_exp", i), 64'(gnt0), 64'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1_exp", i), 64'(gnt1), 64'(tbl[i].g1));
            chk($sformatf("tbl%0d_sel_exp", i), 64'(sel), 64'(tbl[i].s));
            chk($sformatf("tbl%0d_valid_exp", i), 64'(valid), 64'(tbl[i].v));
            chk($sformatf("tbl%0d_out_exp", i), out, tbl[i].o);
        end

        // Early abandon after 2 beats, then a fresh req1 burst runs a full 4 beats.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h70);
        step("ab_grant");
        step("ab_beat1");
        step("ab_beat2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h71);
        step("ab_drop");
        chk("ab_idle_gnt1", 64'(gnt1), 64'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h72);
        step("ab_regrant");
        chk("ab_regrant_gnt1", 64'(gnt1), 64'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h80, 64'h73);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("ab_hold%0d", i));
            chk($sformatf("ab_hold%0d_gnt1", i), 64'(gnt1), 64'h1);
        end
        step("ab_fourth");
        chk("ab_handover_gnt0", 64'(gnt0), 64'h1);
        chk("ab_fourth_out", out, 64'h73);

        // Single requester held across several bursts: grant never drops.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h90);
        step("b2b_first");
        for (int i = 0; i < 9; i++) begin
            data1 = 64'h91 + 64'(i);
            step($sformatf("b2b%0d", i));
            chk($sformatf("b2b%0d_gnt1", i), 64'(gnt1), 64'h1);
            chk($sformatf("b2b%0d_valid", i), 64'(valid), 64'h1);
        end

        // Asynchronous reset in the middle of an OWN1 burst.
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_gnt1", 64'(gnt1), 64'h0);
        chk("arst_valid", 64'(valid), 64'h0);
        chk("arst_out", out, 64'h0);
        chk("arst_sel", 64'(sel), 64'h0);
        #2 reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h5, 64'h6);
        step("arst_after");
        chk("arst_after_gnt0", 64'(gnt0), 64'h1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  {$urandom, $urandom}, {$urandom, $urandom});
            step($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
